// File: rtl/clock_div_multi_if.sv
// rtl/clock_div_multi_if.sv - control/output bundle for the multi-channel clock divider
//
// Purpose: groups the per-channel divisor, enable and sync inputs with the
// divided clock, tick and running outputs of clock_div_multi.
// Signals:
//   div      N_CH*DIV_WIDTH  half-period per channel, slice ch*DIV_WIDTH +: DIV_WIDTH
//   en       N_CH            per-channel run request (level)
//   sync     1               one-cycle pulse, restarts all enabled channels in phase
//   clk_out  N_CH            divided clocks (registered)
//   tick     N_CH            one-cycle pulse at each clk_out rising edge
//   running  N_CH            channel is in RUN state
// Modports: master drives div/en/sync, slave (the divider) drives the outputs.

interface clock_div_multi_if #(
  parameter int N_CH      = 4,
  parameter int DIV_WIDTH = 16
) ();
  logic [N_CH*DIV_WIDTH-1:0] div;
  logic [N_CH-1:0]           en;
  logic                      sync;
  logic [N_CH-1:0]           clk_out;
  logic [N_CH-1:0]           tick;
  logic [N_CH-1:0]           running;

  modport master (
    output div, en, sync,
    input  clk_out, tick, running
  );

  modport slave (
    input  div, en, sync,
    output clk_out, tick, running
  );
endinterface

// File: rtl/clock_div_multi.sv
// rtl/clock_div_multi.sv - N-channel glitch-free 50% duty programmable clock divider
//
// Purpose: generates N_CH independent divided clocks from clk_in. Each channel
// holds clk_out high for d_lat cycles then low for d_lat cycles, where d_lat is
// latched from div only at period boundaries, so pulses are never shortened by
// divisor changes or disables. sync restarts every enabled channel together.
// Ports:
//   clk_in  reference clock, all logic on its rising edge
//   rst     asynchronous active-high reset
//   bus     clock_div_multi_if.slave (div, en, sync in; clk_out, tick, running out)

module clock_div_multi #(
  parameter int N_CH      = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  clock_div_multi_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q [N_CH];
  state_t                 state_d [N_CH];
  logic [DIV_WIDTH-1:0]   cnt_q   [N_CH];
  logic [DIV_WIDTH-1:0]   cnt_d   [N_CH];
  logic [DIV_WIDTH-1:0]   dlat_q  [N_CH];
  logic [DIV_WIDTH-1:0]   dlat_d  [N_CH];
  logic [DIV_WIDTH-1:0]   div_sel [N_CH];
  logic [N_CH-1:0]        clk_q, clk_d;
  logic [N_CH-1:0]        tick_q, tick_d;
  logic [N_CH-1:0]        start;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign div_sel[g]     = bus.div[g*DIV_WIDTH +: DIV_WIDTH];
    // A channel may (re)start only when requested with a nonzero divisor.
    assign start[g]       = bus.en[g] && (div_sel[g] != '0);
    assign bus.running[g] = (state_q[g] == RUN);
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    clk_d   = clk_q;
    tick_d  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (bus.sync) begin
        // sync overrides everything and is the only way to cut a period short.
        cnt_d[ch] = '0;
        if (start[ch]) begin
          state_d[ch] = RUN;
          dlat_d[ch]  = div_sel[ch];
          clk_d[ch]   = 1'b1;
          tick_d[ch]  = 1'b1;
        end else begin
          state_d[ch] = IDLE;
          clk_d[ch]   = 1'b0;
        end
      end else begin
        case (state_q[ch])
          IDLE: begin
            clk_d[ch] = 1'b0;
            if (start[ch]) begin
              state_d[ch] = RUN;
              dlat_d[ch]  = div_sel[ch];
              cnt_d[ch]   = '0;
              clk_d[ch]   = 1'b1;
              tick_d[ch]  = 1'b1;
            end
          end
          RUN: begin
            // d_lat is never 0 in RUN, so d_lat-1 does not wrap.
            if (cnt_q[ch] == dlat_q[ch] - DIV_WIDTH'(1)) begin
              cnt_d[ch] = '0;
              if (clk_q[ch]) begin
                clk_d[ch] = 1'b0;
              end else if (start[ch]) begin
                // Period boundary: the only point where div is re-sampled.
                dlat_d[ch] = div_sel[ch];
                clk_d[ch]  = 1'b1;
                tick_d[ch] = 1'b1;
              end else begin
                state_d[ch] = IDLE;
              end
            end else begin
              cnt_d[ch] = cnt_q[ch] + DIV_WIDTH'(1);
            end
          end
          default: state_d[ch] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
        dlat_q[ch]  <= '0;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        dlat_q[ch]  <= dlat_d[ch];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb/tb_clock_div_multi.sv - self-checking bench for clock_div_multi
//
// Purpose: drives directed vectors into clock_div_multi and compares every
// cycle against a period-position model, plus literal spot checks.
// Ports: none (top-level bench).

module tb_clock_div_multi;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk_in = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  clock_div_multi_if #(.N_CH(N), .DIV_WIDTH(DW)) bus_if ();

  clock_div_multi #(.N_CH(N), .DIV_WIDTH(DW)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  // Model: each active channel tracks its position within the current period
  // (age 0 .. 2*d-1); output is high for the first d positions.
  bit m_act [N];
  int m_age [N];
  int m_d   [N];

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        m_act[ch] = 1'b0;
        m_age[ch] = 0;
        m_d[ch]   = 0;
      end
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        int  dv;
        bit  go;
        dv = int'(bus_if.div[ch*DW +: DW]);
        go = bus_if.en[ch] && (dv != 0);
        if (bus_if.sync) begin
          m_act[ch] = go;
          m_age[ch] = 0;
          if (go) m_d[ch] = dv;
        end else if (m_act[ch]) begin
          m_age[ch] = m_age[ch] + 1;
          if (m_age[ch] == 2 * m_d[ch]) begin
            m_age[ch] = 0;
            if (go) m_d[ch] = dv;
            else    m_act[ch] = 1'b0;
          end
        end else if (go) begin
          m_act[ch] = 1'b1;
          m_age[ch] = 0;
          m_d[ch]   = dv;
        end
      end
    end
  end

  function automatic logic [N-1:0] m_clk();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = m_act[ch] && (m_age[ch] < m_d[ch]);
    return v;
  endfunction

  function automatic logic [N-1:0] m_tick();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = m_act[ch] && (m_age[ch] == 0);
    return v;
  endfunction

  function automatic logic [N-1:0] m_run();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = m_act[ch];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk_in) begin
    check("model clk_out", 32'(bus_if.clk_out), 32'(m_clk()));
    check("model tick",    32'(bus_if.tick),    32'(m_tick()));
    check("model running", 32'(bus_if.running), 32'(m_run()));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_div(input int ch, input int val);
    bus_if.div[ch*DW +: DW] = DW'(val);
  endtask

  int p2 [15] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
  int p3c [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  int p3r [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    rst         = 1'b1;
    bus_if.div  = '0;
    bus_if.en   = '0;
    bus_if.sync = 1'b0;
    step(1);
    check("reset clk_out", 32'(bus_if.clk_out), 32'h0);
    check("reset tick",    32'(bus_if.tick),    32'h0);
    check("reset running", 32'(bus_if.running), 32'h0);
    step(1);
    rst = 1'b0;
    step(2);

    // div=1: toggles every cycle from the first edge
    set_div(0, 1);
    bus_if.en[0] = 1'b1;
    step(1);
    check("div1 first clk",  32'(bus_if.clk_out[0]), 32'h1);
    check("div1 first tick", 32'(bus_if.tick[0]),    32'h1);
    check("div1 running",    32'(bus_if.running[0]), 32'h1);
    step(1);
    check("div1 low",        32'(bus_if.clk_out[0]), 32'h0);
    check("div1 low tick",   32'(bus_if.tick[0]),    32'h0);
    step(1);
    check("div1 high again", 32'(bus_if.clk_out[0]), 32'h1);
    check("div1 tick again", 32'(bus_if.tick[0]),    32'h1);
    bus_if.en[0] = 1'b0;
    step(3);
    check("div1 stopped", 32'(bus_if.running[0]), 32'h0);

    // div 3 -> 5 change during a high phase
    set_div(0, 3);
    bus_if.en[0] = 1'b1;
    step(1);
    check("div3 start tick", 32'(bus_if.tick[0]), 32'h1);
    step(1);
    set_div(0, 5);
    for (int i = 0; i < 15; i++) begin
      step(1);
      check("div3to5 pattern", 32'(bus_if.clk_out[0]), 32'(p2[i]));
    end

    // en dropped in second high cycle of div=4
    bus_if.en[0] = 1'b0;
    step(12);
    set_div(0, 4);
    bus_if.en[0] = 1'b1;
    step(2);
    bus_if.en[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("en drop clk",     32'(bus_if.clk_out[0]), 32'(p3c[i]));
      check("en drop running", 32'(bus_if.running[0]), 32'(p3r[i]));
    end

    // skewed ch0 div2 / ch1 div3 aligned by sync
    set_div(0, 2);
    bus_if.en[0] = 1'b1;
    step(3);
    set_div(1, 3);
    bus_if.en[1] = 1'b1;
    step(2);
    bus_if.sync = 1'b1;
    step(1);
    bus_if.sync = 1'b0;
    check("sync clk",  32'(bus_if.clk_out[1:0]), 32'h3);
    check("sync tick", 32'(bus_if.tick[1:0]),    32'h3);
    step(4);
    check("sync+4 tick", 32'(bus_if.tick[1:0]),    32'h1);
    check("sync+4 clk",  32'(bus_if.clk_out[1:0]), 32'h1);
    step(8);
    check("sync+12 tick", 32'(bus_if.tick[1:0]), 32'h3);

    // ch2 with div=0 stays quiet, then div=7 gives a 14-cycle period
    bus_if.en[2] = 1'b1;
    step(5);
    check("div0 clk",     32'(bus_if.clk_out[2]), 32'h0);
    check("div0 tick",    32'(bus_if.tick[2]),    32'h0);
    check("div0 running", 32'(bus_if.running[2]), 32'h0);
    set_div(2, 7);
    step(1);
    check("div7 tick",  32'(bus_if.tick[2]),    32'h1);
    check("div7 run",   32'(bus_if.running[2]), 32'h1);
    step(6);
    check("div7 age6",  32'(bus_if.clk_out[2]), 32'h1);
    step(1);
    check("div7 age7",  32'(bus_if.clk_out[2]), 32'h0);
    step(6);
    check("div7 age13", 32'(bus_if.clk_out[2]), 32'h0);
    step(1);
    check("div7 age14 tick", 32'(bus_if.tick[2]), 32'h1);

    // async reset mid-high on all channels
    set_div(3, 5);
    bus_if.en   = 4'hf;
    bus_if.sync = 1'b1;
    step(1);
    bus_if.sync = 1'b0;
    check("all sync tick", 32'(bus_if.tick), 32'hf);
    @(posedge clk_in);
    #2;
    check("pre-rst clk", 32'(bus_if.clk_out), 32'hf);
    rst = 1'b1;
    #1;
    check("async rst clk",     32'(bus_if.clk_out), 32'h0);
    check("async rst tick",    32'(bus_if.tick),    32'h0);
    check("async rst running", 32'(bus_if.running), 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    check("post-rst clk",  32'(bus_if.clk_out), 32'hf);
    check("post-rst tick", 32'(bus_if.tick),    32'hf);
    check("post-rst run",  32'(bus_if.running), 32'hf);
    step(1);
    check("post-rst high", 32'(bus_if.clk_out), 32'hf);
    check("post-rst tick0", 32'(bus_if.tick),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
